// File: rtl/memsubsys_pkg.sv
// Shared constants for the picorv32 memory subsystem: FSM encodings, MMIO
// register offsets and the error-counter ceiling.
package memsubsys_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_WAIT   = 2'd1;
    localparam logic [1:0] ST_ACCESS = 2'd2;
    localparam logic [1:0] ST_RESP   = 2'd3;

    localparam logic [1:0] REG_HEX    = 2'd0;
    localparam logic [1:0] REG_LED    = 2'd1;
    localparam logic [1:0] REG_STATUS = 2'd2;
    localparam logic [1:0] REG_ERRCLR = 2'd3;

    localparam int ERR_COUNT_MAX = 255;

    function automatic logic [7:0] sat_inc(input logic [7:0] value);
        return (value == 8'(ERR_COUNT_MAX)) ? value : value + 8'd1;
    endfunction

endpackage

// File: rtl/memsubsys_ram.sv
// Single-port byte-writable RAM with a registered read port, sized for M10K
// inference. INIT_FILE names the board firmware image for the synthesis flow.
module memsubsys_ram #(
   parameter int    MEM_WORDS = 256,
   parameter string INIT_FILE = "firmware.list",
   localparam int   AW        = $clog2(MEM_WORDS)
) (
   input  logic          clk,
   input  logic [AW-1:0] addr,
   input  logic [3:0]    we,
   input  logic [31:0]   wdata,
   output logic [31:0]   rdata
);

   (* ramstyle = "M10K" *) logic [31:0] mem [0:MEM_WORDS-1];

   // Byte-lane writes and a registered read of the addressed word on every clock edge.
   always_ff @(posedge clk) begin
      for (int b = 0; b < 4; b++) begin
         if (we[b]) begin
            mem[addr][8*b +: 8] <= wdata[8*b +: 8];
         end
      end
      rdata <= mem[addr];
   end

endmodule

// File: rtl/picorv32_mem_subsys.sv
// picorv32 native-bus slave: RAM, HEX/LED MMIO window, wait states and bus-error
// reporting. Optional write protection of the low RAM words: MEMSUBSYS_WRPROTECT_EN.
module picorv32_mem_subsys
    import memsubsys_pkg::*;
#(
    parameter int          MEM_WORDS     = 256,
    parameter logic [31:0] RAM_BASE      = 32'h0000_0000,
    parameter logic [31:0] MMIO_BASE     = 32'h1000_0000,
    parameter int          WAIT_STATES   = 0,
    parameter string       INIT_FILE     = "firmware.list",
    parameter int          PROTECT_WORDS = 0
) (
    input  logic        i_clk_50mhz,
    input  logic        i_reset_n,
    input  logic        i_mem_valid,
    input  logic        i_mem_instr,
    input  logic [31:0] i_mem_addr,
    input  logic [31:0] i_mem_wdata,
    input  logic [3:0]  i_mem_wstrb,
    output logic        o_mem_ready,
    output logic [31:0] o_mem_rdata,
    output logic [15:0] o_hex_value,
    output logic [7:0]  o_led,
    output logic        o_bus_err,
    output logic        o_busy
);

    localparam int AW = $clog2(MEM_WORDS);

    logic [1:0]    state;
    logic [3:0]    wait_cnt;
    logic [31:0]   addr_q;
    logic [31:0]   wdata_q;
    logic [3:0]    wstrb_q;
    logic [7:0]    err_count;

    logic [AW-1:0] word_idx;
    logic [31:0]   ram_rdata;
    logic [3:0]    ram_we;
    logic          ram_hit;
    logic          mmio_hit;
    logic          miss;
    logic          is_write;
    logic          prot_hit;
    logic [1:0]    reg_off;
    logic [31:0]   rdata_next;
    logic          unused_bits;

    // RAM_BASE is aligned to the RAM size, so a hit is a match of the upper address bits.
    assign word_idx = addr_q[AW+1:2];
    assign ram_hit  = (addr_q[31:AW+2] == RAM_BASE[31:AW+2]);
    assign mmio_hit = (addr_q[31:4] == MMIO_BASE[31:4]);
    assign miss     = !ram_hit && !mmio_hit;
    assign is_write = |wstrb_q;
    assign reg_off  = addr_q[3:2];
    assign o_busy   = (state != ST_IDLE);

`ifdef MEMSUBSYS_WRPROTECT_EN
    assign prot_hit    = ram_hit && is_write && (32'(word_idx) < 32'(PROTECT_WORDS));
    assign unused_bits = ^{i_mem_instr, addr_q[1:0]};
`else
    assign prot_hit    = 1'b0;
    assign unused_bits = ^{i_mem_instr, addr_q[1:0], 1'(PROTECT_WORDS != 0)};
`endif

    assign ram_we = (state == ST_ACCESS && ram_hit && !prot_hit) ? wstrb_q : 4'b0000;

    // The RAM address is stable from WAIT onward, so its registered output is ready in ACCESS.
    memsubsys_ram #(
        .MEM_WORDS (MEM_WORDS),
        .INIT_FILE (INIT_FILE)
    ) u_ram (
        .clk   (i_clk_50mhz),
        .addr  (word_idx),
        .we    (ram_we),
        .wdata (wdata_q),
        .rdata (ram_rdata)
    );

    always_comb begin
        rdata_next = 32'h0;
        if (!is_write) begin
            if (ram_hit) begin
                rdata_next = ram_rdata;
            end else if (mmio_hit) begin
                case (reg_off)
                    REG_HEX:    rdata_next = {16'h0, o_hex_value};
                    REG_LED:    rdata_next = {24'h0, o_led};
                    REG_STATUS: rdata_next = {16'h0, err_count, 7'h0, o_bus_err};
                    default:    rdata_next = 32'h0;
                endcase
            end
        end
    end

    always_ff @(posedge i_clk_50mhz or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state       <= ST_IDLE;
            wait_cnt    <= 4'd0;
            addr_q      <= 32'h0;
            wdata_q     <= 32'h0;
            wstrb_q     <= 4'h0;
            err_count   <= 8'h0;
            o_mem_ready <= 1'b0;
            o_mem_rdata <= 32'h0;
            o_hex_value <= 16'h0;
            o_led       <= 8'h0;
            o_bus_err   <= 1'b0;
        end else begin
            o_mem_ready <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (i_mem_valid) begin
                        addr_q   <= i_mem_addr;
                        wdata_q  <= i_mem_wdata;
                        wstrb_q  <= i_mem_wstrb;
                        wait_cnt <= 4'(WAIT_STATES);
                        state    <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (wait_cnt == 4'd0) begin
                        state <= ST_ACCESS;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                ST_ACCESS: begin
                    o_mem_ready <= 1'b1;
                    o_mem_rdata <= rdata_next;
                    state       <= ST_RESP;
                    if (miss || prot_hit) begin
                        o_bus_err <= 1'b1;
                        err_count <= sat_inc(err_count);
                    end else if (mmio_hit && !ram_hit && is_write) begin
                        case (reg_off)
                            REG_HEX: begin
                                if (wstrb_q[0]) o_hex_value[7:0]  <= wdata_q[7:0];
                                if (wstrb_q[1]) o_hex_value[15:8] <= wdata_q[15:8];
                            end
                            REG_LED: begin
                                if (wstrb_q[0]) o_led <= wdata_q[7:0];
                            end
                            REG_ERRCLR: begin
                                o_bus_err <= 1'b0;
                                err_count <= 8'h0;
                            end
                            default: ;
                        endcase
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_picorv32_mem_subsys.sv
// Scoreboard bench for picorv32_mem_subsys: a behavioural model predicts every
// response at issue time and a negedge monitor compares when o_mem_ready pulses.
module tb_picorv32_mem_subsys;

    localparam int          WS   = 2;
    localparam int          MW   = 256;
    localparam int          PW   = 16;
    localparam logic [31:0] MMIO = 32'h1000_0000;

    logic        clk;
    logic        rst_n;
    logic        mem_valid;
    logic        mem_instr;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic [15:0] hex_value;
    logic [7:0]  led;
    logic        bus_err;
    logic        busy;

    picorv32_mem_subsys #(
        .MEM_WORDS     (MW),
        .RAM_BASE      (32'h0000_0000),
        .MMIO_BASE     (MMIO),
        .WAIT_STATES   (WS),
        .INIT_FILE     (""),
        .PROTECT_WORDS (PW)
    ) dut (
        .i_clk_50mhz (clk),
        .i_reset_n   (rst_n),
        .i_mem_valid (mem_valid),
        .i_mem_instr (mem_instr),
        .i_mem_addr  (mem_addr),
        .i_mem_wdata (mem_wdata),
        .i_mem_wstrb (mem_wstrb),
        .o_mem_ready (mem_ready),
        .o_mem_rdata (mem_rdata),
        .o_hex_value (hex_value),
        .o_led       (led),
        .o_bus_err   (bus_err),
        .o_busy      (busy)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    typedef struct {
        logic        is_read;
        logic [31:0] rdata;
        logic [15:0] hex;
        logic [7:0]  led;
        logic        err;
        int          issue;
    } exp_t;

    exp_t sb[$];
    int   errors    = 0;
    int   checks    = 0;
    int   cycle_cnt = 0;

    // Reference state: RAM image plus which words hold a known value, and the MMIO view.
    logic [31:0] ref_mem   [MW];
    bit          ref_known [MW];
    logic [15:0] ref_hex;
    logic [7:0]  ref_led;
    logic        ref_err;
    int          ref_cnt;

    always @(posedge clk) cycle_cnt++;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cycle_cnt);
        end
    endtask

    function automatic void modelReset();
        ref_hex = 16'h0;
        ref_led = 8'h0;
        ref_err = 1'b0;
        ref_cnt = 0;
    endfunction

    function automatic void modelError();
        ref_err = 1'b1;
        if (ref_cnt < 255) ref_cnt++;
    endfunction

    function automatic exp_t modelAccess(input logic [31:0] addr, input logic [31:0] wdata,
                                         input logic [3:0] wstrb);
        exp_t e;
        int   idx;
        int   off;
        bit   wr;
        bit   prot;
        e.is_read = 1'b0;
        e.rdata   = 32'h0;
        wr        = (wstrb != 4'h0);
        if (addr < 32'(4 * MW)) begin
            idx  = int'(addr / 4);
            prot = 1'b0;
`ifdef MEMSUBSYS_WRPROTECT_EN
            prot = wr && (idx < PW);
`endif
            if (prot) begin
                modelError();
            end else if (wr) begin
                for (int b = 0; b < 4; b++) begin
                    if (wstrb[b]) ref_mem[idx][8*b +: 8] = wdata[8*b +: 8];
                end
                if (wstrb == 4'hF) ref_known[idx] = 1'b1;
            end else begin
                e.is_read = ref_known[idx];
                e.rdata   = ref_mem[idx];
            end
        end else if ((addr >> 4) == (MMIO >> 4)) begin
            off = int'((addr >> 2) & 32'd3);
            if (wr) begin
                if (off == 0) begin
                    if (wstrb[0]) ref_hex[7:0]  = wdata[7:0];
                    if (wstrb[1]) ref_hex[15:8] = wdata[15:8];
                end else if (off == 1) begin
                    if (wstrb[0]) ref_led = wdata[7:0];
                end else if (off == 3) begin
                    ref_err = 1'b0;
                    ref_cnt = 0;
                end
            end else begin
                e.is_read = 1'b1;
                case (off)
                    0:       e.rdata = {16'h0, ref_hex};
                    1:       e.rdata = {24'h0, ref_led};
                    2:       e.rdata = ref_cnt * 256 + (ref_err ? 1 : 0);
                    default: e.rdata = 32'h0;
                endcase
            end
        end else begin
            e.is_read = !wr;
            e.rdata   = 32'h0;
            modelError();
        end
        e.hex = ref_hex;
        e.led = ref_led;
        e.err = ref_err;
        return e;
    endfunction

    // Drive one request from a negedge, hold it until the ready pulse, then release.
    task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic [3:0] wstrb);
        exp_t e;
        bit   got;
        @(negedge clk);
        mem_valid = 1'b1;
        mem_instr = $urandom_range(0, 1) == 1;
        mem_addr  = addr;
        mem_wdata = wdata;
        mem_wstrb = wstrb;
        e         = modelAccess(addr, wdata, wstrb);
        e.issue   = cycle_cnt;
        sb.push_back(e);
        got = 1'b0;
        for (int t = 0; t < 40; t++) begin
            @(negedge clk);
            if (mem_ready) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            checks++;
            errors++;
            $display("[TB] FAIL ready_timeout: no ready for addr %h, required within 40 cycles", addr);
            void'(sb.pop_back());
        end
        mem_valid = 1'b0;
    endtask

    logic prev_ready = 1'b0;

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && mem_ready) begin
            checkOutput("ready_width", 32'(prev_ready), 32'h0);
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_ready: got ready=1 with no request outstanding, required 0");
            end else begin
                e = sb.pop_front();
                checkOutput("latency", 32'(cycle_cnt - e.issue), 32'(3 + WS));
                if (e.is_read) checkOutput("rdata", mem_rdata, e.rdata);
                checkOutput("hex", 32'(hex_value), 32'(e.hex));
                checkOutput("led", 32'(led), 32'(e.led));
                checkOutput("bus_err", 32'(bus_err), 32'(e.err));
            end
        end
        prev_ready = mem_ready;
    end

    function automatic logic [31:0] randAddr();
        int r;
        r = $urandom_range(0, 9);
        if (r <= 5) return 32'($urandom_range(0, MW - 1) * 4 + $urandom_range(0, 3));
        if (r <= 7) return MMIO + 32'($urandom_range(0, 15));
        return 32'h0000_0400 + 32'($urandom_range(0, 4095));
    endfunction

    initial begin
        logic [3:0] strb;
        rst_n     = 1'b0;
        mem_valid = 1'b0;
        mem_instr = 1'b0;
        mem_addr  = 32'h0;
        mem_wdata = 32'h0;
        mem_wstrb = 4'h0;
        modelReset();
        for (int i = 0; i < MW; i++) ref_known[i] = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset_ready", 32'(mem_ready), 32'h0);
        checkOutput("reset_rdata", mem_rdata, 32'h0);
        checkOutput("reset_hex", 32'(hex_value), 32'h0);
        checkOutput("reset_led", 32'(led), 32'h0);
        checkOutput("reset_err", 32'(bus_err), 32'h0);
        checkOutput("reset_busy", 32'(busy), 32'h0);
        rst_n = 1'b1;

        for (int i = 0; i < MW; i++) applyStimulus(32'(i * 4), $urandom, 4'hF);

        applyStimulus(32'h4, 32'hDEAD_BEEF, 4'hF);
        applyStimulus(32'h4, 32'h0, 4'h0);
        applyStimulus(32'h10, 32'hAABB_CCDD, 4'hF);
        applyStimulus(32'h10, 32'h1122_3344, 4'b0101);
        applyStimulus(32'h10, 32'h0, 4'h0);

        applyStimulus(MMIO + 32'h0, 32'h0000_1234, 4'hF);
        applyStimulus(MMIO + 32'h4, 32'h0000_005A, 4'hF);
        applyStimulus(MMIO + 32'h0, 32'h0, 4'h0);
        applyStimulus(MMIO + 32'h4, 32'h0, 4'h0);

        applyStimulus(MMIO + 32'hC, 32'h0, 4'hF);
        repeat (3) applyStimulus(32'h0000_2000, 32'h0, 4'h0);
        applyStimulus(MMIO + 32'h8, 32'h0, 4'h0);
        applyStimulus(MMIO + 32'hC, 32'hFFFF_FFFF, 4'h1);
        applyStimulus(MMIO + 32'h8, 32'h0, 4'h0);

        repeat (260) applyStimulus(32'h0000_2000, 32'h0, 4'h0);
        applyStimulus(MMIO + 32'h8, 32'h0, 4'h0);
        applyStimulus(MMIO + 32'hC, 32'h0, 4'hF);

        applyStimulus(32'h8, 32'hFFFF_FFFF, 4'hF);
        applyStimulus(32'h8, 32'h0, 4'h0);
        applyStimulus(32'h40, 32'h0BAD_F00D, 4'hF);
        applyStimulus(32'h40, 32'h0, 4'h0);

        for (int i = 0; i < 300; i++) begin
            strb = ($urandom_range(0, 1) == 1) ? 4'h0 : 4'($urandom_range(1, 15));
            applyStimulus(randAddr(), $urandom, strb);
        end

        // Reset while the request sits in WAIT: nothing may complete or be written.
        @(negedge clk);
        mem_valid = 1'b1;
        mem_addr  = 32'h20;
        mem_wdata = 32'hCAFE_0001;
        mem_wstrb = 4'hF;
        @(negedge clk);
        checkOutput("busy_in_wait", 32'(busy), 32'h1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("abort_busy", 32'(busy), 32'h0);
        checkOutput("abort_ready", 32'(mem_ready), 32'h0);
        checkOutput("abort_hex", 32'(hex_value), 32'h0);
        checkOutput("abort_led", 32'(led), 32'h0);
        checkOutput("abort_err", 32'(bus_err), 32'h0);
        mem_valid = 1'b0;
        modelReset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(32'h20, 32'h0, 4'h0);
        applyStimulus(MMIO + 32'h8, 32'h0, 4'h0);

        for (int t = 0; t < 20 && sb.size() != 0; t++) @(negedge clk);
        checkOutput("scoreboard_drained", 32'(sb.size()), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
